// File: rtl/dice_turn_ctrl_if.sv
// dice_turn_ctrl_if
// Bundles the player-side and dice-core-side signals of the turn scheduler.
//   req           : level push-button per player (bit i = player i)
//   throw         : current face value reported by the dice core
//   score_clr     : synchronous clear of every player's score
//   dice_button   : roll enable driven into the dice core
//   grant         : one-hot owner of the current turn, zero when idle
//   result_valid  : one-cycle pulse when a turn result is available
//   result_player : index of the player whose turn just completed
//   result_value  : captured throw of that turn
//   result_err    : captured throw was 0 or 7 and was not scored
//   score         : packed per-player scores, player i at [i*SCORE_W +: SCORE_W]
//   timeout       : only with DICE_TURN_TIMEOUT_EN, turn ended by roll time limit
// master modport = player/test side, slave modport = dice_turn_ctrl.
interface dice_turn_ctrl_if #(
    parameter int N_PLAYERS = 4,
    parameter int SCORE_W   = 8,
    parameter int PID_W     = 2
);
    logic [N_PLAYERS-1:0]         req;
    logic [2:0]                   throw;
    logic                         score_clr;
    logic                         dice_button;
    logic [N_PLAYERS-1:0]         grant;
    logic                         result_valid;
    logic [PID_W-1:0]             result_player;
    logic [2:0]                   result_value;
    logic                         result_err;
    logic [N_PLAYERS*SCORE_W-1:0] score;
`ifdef DICE_TURN_TIMEOUT_EN
    logic                         timeout;

    modport master (
        output req, throw, score_clr,
        input  dice_button, grant, result_valid, result_player,
               result_value, result_err, score, timeout
    );

    modport slave (
        input  req, throw, score_clr,
        output dice_button, grant, result_valid, result_player,
               result_value, result_err, score, timeout
    );
`else
    modport master (
        output req, throw, score_clr,
        input  dice_button, grant, result_valid, result_player,
               result_value, result_err, score
    );

    modport slave (
        input  req, throw, score_clr,
        output dice_button, grant, result_valid, result_player,
               result_value, result_err, score
    );
`endif
endinterface

// File: rtl/dice_turn_ctrl.sv
// dice_turn_ctrl
// Shares one electronic dice between N_PLAYERS players. Player buttons are
// arbitrated round-robin; the granted player's turn drives the dice roll
// button for at least MIN_ROLL_CYCLES, then the settled throw is captured
// and added to that player's saturating score.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : dice_turn_ctrl_if slave modport (req/throw/score_clr in,
//         dice_button/grant/result_*/score out)
// Optional feature macro: DICE_TURN_TIMEOUT_EN
//   Adds parameter MAX_ROLL_CYCLES and the interface output timeout; a
//   button held until roll_cnt reaches MAX_ROLL_CYCLES forces the turn to end.
module dice_turn_ctrl #(
    parameter int N_PLAYERS       = 4,
    parameter int MIN_ROLL_CYCLES = 8,
    parameter int SCORE_W         = 8,
    parameter int PID_W           = 2
`ifdef DICE_TURN_TIMEOUT_EN
   ,parameter int MAX_ROLL_CYCLES = 64
`endif
) (
    input logic             clk,
    input logic             rst,
    dice_turn_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROLL, SETTLE, CAPTURE} state_t;

`ifdef DICE_TURN_TIMEOUT_EN
    localparam int CNT_LIMIT = MAX_ROLL_CYCLES;
`else
    localparam int CNT_LIMIT = MIN_ROLL_CYCLES;
`endif
    localparam int               CNT_W   = $clog2(CNT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_ROLL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_LIMIT);

    state_t                 state;
    logic [PID_W-1:0]       ptr;
    logic [CNT_W-1:0]       roll_cnt;
    logic [SCORE_W-1:0]     scores [N_PLAYERS];
    logic                   dice_button_q;
    logic [N_PLAYERS-1:0]   grant_q;
    logic                   result_valid_q;
    logic [PID_W-1:0]       result_player_q;
    logic [2:0]             result_value_q;
    logic                   result_err_q;
`ifdef DICE_TURN_TIMEOUT_EN
    logic                   timed_out;
    logic                   timeout_q;
`endif

    logic                   any_req;
    logic [PID_W-1:0]       sel;
    logic [PID_W-1:0]       idx;
    logic                   throw_ok;
    logic [SCORE_W+2:0]     sum;
    logic [SCORE_W-1:0]     sat_score;

    // Round-robin pick: scan from the player after the last owner, wrapping,
    // and keep the first requester found.
    always_comb begin
        any_req = 1'b0;
        sel     = ptr;
        idx     = ptr;
        for (int i = 1; i <= N_PLAYERS; i++) begin
            idx = PID_W'((int'(ptr) + i) % N_PLAYERS);
            if (!any_req && bus.req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    // Saturating score update for the current owner; extra headroom bits
    // make the overflow check a simple compare.
    always_comb begin
        throw_ok  = (bus.throw != 3'd0) && (bus.throw != 3'd7);
        sum       = {3'b000, scores[ptr]} + {{SCORE_W{1'b0}}, bus.throw};
        sat_score = (sum > {3'b000, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}}
                                                       : sum[SCORE_W-1:0];
    end

    // Turn FSM. The pointer doubles as the current owner index once a turn
    // is granted. score_clr is applied last so it overrides a same-cycle
    // score update while the result itself is still reported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ptr             <= PID_W'(N_PLAYERS - 1);
            roll_cnt        <= '0;
            dice_button_q   <= 1'b0;
            grant_q         <= '0;
            result_valid_q  <= 1'b0;
            result_player_q <= '0;
            result_value_q  <= '0;
            result_err_q    <= 1'b0;
`ifdef DICE_TURN_TIMEOUT_EN
            timed_out       <= 1'b0;
            timeout_q       <= 1'b0;
`endif
            for (int i = 0; i < N_PLAYERS; i++) begin
                scores[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q       <= N_PLAYERS'(1) << sel;
                        ptr           <= sel;
                        dice_button_q <= 1'b1;
                        roll_cnt      <= CNT_W'(1);
                        state         <= ROLL;
                    end
                end
                ROLL: begin
                    if (!bus.req[ptr] && (roll_cnt >= CNT_MIN)) begin
                        dice_button_q <= 1'b0;
                        roll_cnt      <= '0;
                        state         <= SETTLE;
`ifdef DICE_TURN_TIMEOUT_EN
                    end else if (roll_cnt >= CNT_SAT) begin
                        dice_button_q <= 1'b0;
                        roll_cnt      <= '0;
                        timed_out     <= 1'b1;
                        state         <= SETTLE;
`endif
                    end else if (roll_cnt < CNT_SAT) begin
                        roll_cnt <= roll_cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    result_value_q  <= bus.throw;
                    result_player_q <= ptr;
                    result_valid_q  <= 1'b1;
                    result_err_q    <= !throw_ok;
                    if (throw_ok) begin
                        scores[ptr] <= sat_score;
                    end
`ifdef DICE_TURN_TIMEOUT_EN
                    timeout_q <= timed_out;
                    timed_out <= 1'b0;
`endif
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    result_valid_q <= 1'b0;
                    result_err_q   <= 1'b0;
                    grant_q        <= '0;
`ifdef DICE_TURN_TIMEOUT_EN
                    timeout_q      <= 1'b0;
`endif
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.score_clr) begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    scores[i] <= '0;
                end
            end
        end
    end

    assign bus.dice_button   = dice_button_q;
    assign bus.grant         = grant_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.result_player = result_player_q;
    assign bus.result_value  = result_value_q;
    assign bus.result_err    = result_err_q;
`ifdef DICE_TURN_TIMEOUT_EN
    assign bus.timeout       = timeout_q;
`endif

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
        assign bus.score[g*SCORE_W +: SCORE_W] = scores[g];
    end

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// tb_dice_turn_ctrl
// Drives dice_turn_ctrl through reset, directed turns and randomized turns,
// comparing against a turn-level reference model (round-robin pick, roll
// duration, saturating scores) held in the bench.
// Honours DICE_TURN_TIMEOUT_EN when the design is built with it.
module tb_dice_turn_ctrl;
    localparam int N   = 4;
    localparam int MIN = 8;
    localparam int SW  = 8;
    localparam int PW  = 2;
`ifdef DICE_TURN_TIMEOUT_EN
    localparam int MAXC = 64;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dice_turn_ctrl_if #(.N_PLAYERS(N), .SCORE_W(SW), .PID_W(PW)) bus ();

    dice_turn_ctrl #(
        .N_PLAYERS(N),
        .MIN_ROLL_CYCLES(MIN),
        .SCORE_W(SW),
        .PID_W(PW)
`ifdef DICE_TURN_TIMEOUT_EN
       ,.MAX_ROLL_CYCLES(MAXC)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: last owner and each player's score as plain integers.
    int ptr_m;
    int score_m [N];

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (ptr_m + i) % N;
            if (mask[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N*SW-1:0] exp_scores();
        logic [N*SW-1:0] v;
        for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'(score_m[i]);
        return v;
    endfunction

    task automatic model_reset();
        ptr_m = N - 1;
        for (int i = 0; i < N; i++) score_m[i] = 0;
    endtask

    // One complete turn, entered from an IDLE cycle. The request mask is
    // presented for that IDLE cycle; the owner keeps its button for 'hold'
    // cycles in total (including the IDLE cycle), other bits stay as masked.
    task automatic apply_stimulus(input logic [N-1:0] mask, input int hold,
                                  input logic [2:0] throw_val, input bit clr);
        int w;
        int k;
        int high;
        int exp_high;
        bit exp_to;
        bit valid_throw;
        w = model_pick(mask);
        @(negedge clk);
        bus.req   = mask;
        bus.throw = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        check_output("grant", 64'(bus.grant), 64'(1 << w));
        check_output("button_on", 64'(bus.dice_button), 64'(1));
        ptr_m = w;
        high  = 1;
        k     = 1;
        while (k < 2000) begin
            @(negedge clk);
            bus.req    = mask;
            bus.req[w] = (k < hold);
            bus.throw  = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            if (!bus.dice_button) break;
            high++;
            k++;
        end
        exp_high = (hold > MIN) ? hold : MIN;
        exp_to   = 1'b0;
`ifdef DICE_TURN_TIMEOUT_EN
        if (exp_high > MAXC) exp_high = MAXC;
        exp_to = (hold > MAXC);
`endif
        check_output("button_high_cycles", 64'(high), 64'(exp_high));
        @(negedge clk);
        bus.throw     = throw_val;
        bus.score_clr = clr;
        valid_throw = (throw_val >= 3'd1) && (throw_val <= 3'd6);
        if (clr) begin
            for (int i = 0; i < N; i++) score_m[i] = 0;
        end else if (valid_throw) begin
            score_m[w] = score_m[w] + int'(throw_val);
            if (score_m[w] > (1 << SW) - 1) score_m[w] = (1 << SW) - 1;
        end
        @(posedge clk);
        #1;
        check_output("result_valid", 64'(bus.result_valid), 64'(1));
        check_output("result_player", 64'(bus.result_player), 64'(w));
        check_output("result_value", 64'(bus.result_value), 64'(throw_val));
        check_output("result_err", 64'(bus.result_err), 64'(!valid_throw));
        check_output("score", 64'(bus.score), 64'(exp_scores()));
`ifdef DICE_TURN_TIMEOUT_EN
        check_output("timeout", 64'(bus.timeout), 64'(exp_to));
`else
        if (exp_to) check_output("timeout_model", 64'(0), 64'(1));
`endif
        @(negedge clk);
        bus.req       = '0;
        bus.score_clr = 1'b0;
        bus.throw     = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        check_output("valid_drop", 64'(bus.result_valid), 64'(0));
        check_output("grant_idle", 64'(bus.grant), 64'(0));
        check_output("value_hold", 64'(bus.result_value), 64'(throw_val));
    endtask

    initial begin
        bus.req       = '0;
        bus.throw     = '0;
        bus.score_clr = 1'b0;
        rst           = 1'b0;
        model_reset();

        // Reset with every player pressing.
        bus.req = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_grant", 64'(bus.grant), 64'(0));
        check_output("rst_button", 64'(bus.dice_button), 64'(0));
        check_output("rst_score", 64'(bus.score), 64'(0));
        check_output("rst_valid", 64'(bus.result_valid), 64'(0));
        check_output("rst_value", 64'(bus.result_value), 64'(0));
        rst = 1'b1;
        apply_stimulus(4'b1111, 3, 3'd4, 1'b0);

        // Short press by player 2.
        apply_stimulus(4'b0100, 2, 3'd5, 1'b0);

        // Round-robin with everyone requesting.
        for (int t = 0; t < 5; t++) apply_stimulus(4'b1111, 1 + t * 3, 3'(1 + t), 1'b0);

        // Invalid throws are reported but not scored.
        apply_stimulus(4'b0001, 4, 3'd7, 1'b0);
        apply_stimulus(4'b1000, 9, 3'd0, 1'b0);

        // Clear while idle.
        @(negedge clk);
        bus.score_clr = 1'b1;
        for (int i = 0; i < N; i++) score_m[i] = 0;
        @(posedge clk);
        #1;
        check_output("idle_clear", 64'(bus.score), 64'(0));
        @(negedge clk);
        bus.score_clr = 1'b0;

        // Saturation of player 1: 42*6 + 1 = 253, then +6 clips to 255.
        for (int t = 0; t < 42; t++) apply_stimulus(4'b0010, 1, 3'd6, 1'b0);
        apply_stimulus(4'b0010, 1, 3'd1, 1'b0);
        check_output("score1_253", 64'(bus.score[1*SW +: SW]), 64'(253));
        apply_stimulus(4'b0010, 1, 3'd6, 1'b0);
        check_output("score1_sat", 64'(bus.score[1*SW +: SW]), 64'(255));

        // Clear coinciding with a capture wins over the update.
        apply_stimulus(4'b0100, 3, 3'd5, 1'b1);

        // Randomized turns.
        for (int t = 0; t < 25; t++) begin
            apply_stimulus(4'($urandom_range(1, 15)), int'($urandom_range(1, 14)),
                           3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
        end

`ifdef DICE_TURN_TIMEOUT_EN
        // Held button is cut off at the roll limit.
        apply_stimulus(4'b1000, 100, 3'd4, 1'b0);
`endif

        // Reset in the middle of a roll drops the button immediately.
        @(negedge clk);
        bus.req = 4'b0100;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst_button", 64'(bus.dice_button), 64'(0));
        check_output("midrst_grant", 64'(bus.grant), 64'(0));
        check_output("midrst_score", 64'(bus.score), 64'(0));
        model_reset();
        @(negedge clk);
        bus.req = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(4'b0110, 2, 3'd3, 1'b0);

        $display("[TB] directed and random turns complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
